// File: rtl/button_conditioner.sv
// Push-button front end: synchronizes and debounces the raw pin, then produces
// registered press/release/auto-repeat strobes for the up/down counter.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 20,
    parameter int REPEAT_CYCLES   = 5,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic button_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic count_enable
);

    localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic          buttonIn;
    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [DW-1:0] debCnt_q, debCnt_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;
    logic          differ, debDone, rise, fall;

    assign buttonIn = button ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            debCnt_q  <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= buttonIn;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            debCnt_q  <= debCnt_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    // Any cycle where the synchronized input agrees with the debounced level restarts the count.
    always_comb begin
        differ   = (sync2_q != stable_q);
        debDone  = differ && (debCnt_q == DEB_LAST);
        stable_d = stable_q;
        debCnt_d = '0;
        if (debDone) begin
            stable_d = ~stable_q;
        end else if (differ) begin
            debCnt_d = debCnt_q + DW'(1);
        end
        rise = debDone && !stable_q;
        fall = debDone && stable_q;
    end

    // The release is checked first so that it beats a repeat expiring on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = HOLD;
                    press_d = 1'b1;
                end
            end
            HOLD: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d  = REPEAT;
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign button_state  = stable_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign count_enable  = press_q | repeat_q;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Synchronizes, debounces and edge-detects the raw push-button input for the up/down counter datapath. Sits directly upstream of the counter: it takes the asynchronous `button` pin and produces a clean level plus single-cycle press, release and auto-repeat strobes. The counter consumes these as count enables. It runs on the divided clock produced by the clock divider.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before the debounced level changes; legal range ≥ 2.
- `HOLD_CYCLES`, 20: cycles from `press_pulse` to the first `repeat_pulse`; legal range ≥ 2.
- `REPEAT_CYCLES`, 5: period between consecutive `repeat_pulse`s while held; legal range ≥ 2.
- `ACTIVE_LOW`, 0: when 1, `button` is inverted at the input (pressed = 0).
- `clk` in 1: single clock (divided clock); all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `button` in 1: raw, asynchronous, bouncing button pin.
- `button_state` out 1: debounced level, 1 = pressed.
- `press_pulse` out 1: one-cycle strobe on the debounced 0→1 transition.
- `release_pulse` out 1: one-cycle strobe on the debounced 1→0 transition.
- `repeat_pulse` out 1: one-cycle auto-repeat strobe while held.
- `count_enable` out 1: `press_pulse | repeat_pulse`; drives the counter enable.

## Operation
- Input path: optional inversion, then a two-flop synchronizer (`sync1` → `sync2`). Only `sync2` is used downstream.
- Debounce counter: width is ceil(log2(DEBOUNCE_CYCLES)).
  - It increments on every edge where `sync2 != button_state`.
  - It clears to 0 on any edge where they are equal, so any bounce restarts the count.
  - On the edge where `sync2 != button_state` and the counter equals DEBOUNCE_CYCLES-1, `button_state` toggles and the counter clears.
- FSM, registered, three states:
  - IDLE: released. On the debounced rise, go to HOLD, assert `press_pulse` and clear the hold counter.
  - HOLD: pressed, counting toward HOLD_CYCLES. When the counter reaches HOLD_CYCLES-1, go to REPEAT, assert `repeat_pulse` and clear the counter. On the debounced fall, go to IDLE and assert `release_pulse`.
  - REPEAT: the counter counts to REPEAT_CYCLES-1, then asserts `repeat_pulse` and clears; the state stays REPEAT. On the debounced fall, go to IDLE and assert `release_pulse`.
- Hold/repeat counter: one shared counter, wide enough for max(HOLD_CYCLES, REPEAT_CYCLES)-1. Held at 0 in IDLE.
- Simultaneous fall and repeat expiry: the release wins. `release_pulse` = 1, `repeat_pulse` = 0.
- `press_pulse`, `release_pulse` and `repeat_pulse` are mutually exclusive in every cycle.
- `count_enable` is the combinational OR of two registered outputs. There are no other combinational outputs.

## Timing
- Reset values: `sync1`, `sync2`, `button_state` and all pulses = 0; state = IDLE; all counters = 0.
  - `rst` has priority over all other activity in the same cycle.
  - Asserting `rst` mid-hold or mid-repeat drops every output to 0 on the next edge.
- Latency: a clean level change first sampled by `sync1` at edge k updates `button_state` at edge k+DEBOUNCE_CYCLES+1.
  - `press_pulse` or `release_pulse` is high for exactly the one cycle following that same edge.
  - Default latency: raw rise sampled at edge 0 → `button_state` = 1 and `press_pulse` = 1 after edge 5.
- Repeat timing: with `press_pulse` in cycle P, `repeat_pulse` fires in cycles P+HOLD_CYCLES, then P+HOLD_CYCLES+n·REPEAT_CYCLES for n ≥ 1.
- Glitch rejection: a level held for fewer than DEBOUNCE_CYCLES consecutive `sync2` cycles produces no output change.
- Button held through reset: `button_state` is 0 after reset. The held level is then treated as a new press and produces `press_pulse` after the normal latency.

## Test plan
- Reset and clean press:
  - Stimulus: `rst` for 3 cycles, then `button` 0→1 and held 10 cycles.
  - Response: all outputs 0 during reset. `button_state` rises 5 edges after first sample. `press_pulse` and `count_enable` are high for exactly 1 cycle. No `repeat_pulse` before cycle P+20.
- Bounce:
  - Stimulus: `button` toggles 1,0,1,0 with 1–3-cycle widths, then settles at 1.
  - Response: no strobes during the bounce. Exactly one `press_pulse`, 5 edges after the final stable sample.
- Auto-repeat:
  - Stimulus: hold pressed for 40 cycles after `press_pulse` in cycle P.
  - Response: `repeat_pulse` in cycles P+20, P+25, P+30, P+35, P+40. `count_enable` is high in those cycles and in P, and low otherwise.
- Release collision:
  - Stimulus: time the release so the debounced fall lands in cycle P+25.
  - Response: `release_pulse` = 1 and `repeat_pulse` = 0 in P+25. State returns to IDLE with no further strobes.
- Reset mid-repeat:
  - Stimulus: assert `rst` for 1 cycle while in REPEAT, with the button still held.
  - Response: all outputs 0 on the next edge. A new `press_pulse` follows 5 edges after `rst` deasserts. Repeat timing restarts from that press.
- ACTIVE_LOW = 1:
  - Stimulus: `button` 1→0, then 0→1.
  - Response: `press_pulse`, then `release_pulse`, with the same latencies as the active-high case.
